// File: rtl/gate_tt_sequencer_pkg.sv
// Shared definitions for the gate truth-table sequencer: state encodings,
// vector count and index/counter widths.
package gate_tt_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    localparam int NUM_VEC = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 4;
    localparam int ERR_W   = 8;

endpackage

// File: rtl/gate_seq_timer.sv
// Settle timer: loads a count, counts down while enabled, flags expiry at zero.
module gate_seq_timer
    import gate_tt_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/gate_tt_sequencer.sv
// Walks a 2-input gate through its four input vectors and checks its output
// against EXPECT. Define GATE_SEQ_ERRCNT_EN to add the saturating err_cnt output.
module gate_tt_sequencer
    import gate_tt_sequencer_pkg::*;
#(
    parameter int                 SETTLE_CYCLES = 2,
    parameter logic [NUM_VEC-1:0] EXPECT        = 4'b1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               c,
    output logic               a,
    output logic               b,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_VEC-1:0] fail_mask
`ifdef GATE_SEQ_ERRCNT_EN
   ,output logic [ERR_W-1:0]   err_cnt
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    seq_state_t         state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_inc;
    logic               settle_exp;
    logic               mismatch;
    logic [NUM_VEC-1:0] mask_upd;

    // SETTLE lasts SETTLE_CYCLES cycles: loaded with N-1 in APPLY, expires at zero.
    gate_seq_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ST_APPLY),
        .load_val (CNT_W'(SETTLE_CYCLES - 1)),
        .en       (state == ST_SETTLE),
        .expired  (settle_exp)
    );

    assign idx_inc  = idx + 1'b1;
    assign mismatch = (state == ST_CHECK) && (c != EXPECT[idx]);
    assign mask_upd = fail_mask | (mismatch ? (NUM_VEC'(1) << idx) : '0);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_APPLY;
            ST_APPLY:  state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_exp) state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = (idx == LAST_IDX) ? ST_DONE : ST_APPLY;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // a/b are loaded on the edge entering APPLY so they are valid throughout APPLY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        a         <= 1'b0;
                        b         <= 1'b0;
                        pass      <= 1'b0;
                        fail_mask <= '0;
                    end
                end
                ST_CHECK: begin
                    fail_mask <= mask_upd;
                    if (idx == LAST_IDX) begin
                        pass <= (mask_upd == '0);
                    end else begin
                        idx <= idx_inc;
                        a   <= idx_inc[1];
                        b   <= idx_inc[0];
                    end
                end
                ST_DONE: begin
                    a <= 1'b0;
                    b <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef GATE_SEQ_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (mismatch && err_cnt != {ERR_W{1'b1}})
            err_cnt <= err_cnt + 1'b1;
    end
`endif

endmodule
